// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller and its testbench.
//   - SRAM_DW / SRAM_AW : external SRAM data width (16) and halfword address width (18)
//   - state_e           : controller FSM encoding, also exported on the debug port
package sram_controller_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM by
// splitting each word into a low and a high halfword access, each held on
// the SRAM pins for SRAM_WAIT cycles.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   wr_en, rd_en      store / load request (both high = store)
//   address           byte address; ADDR_BASE maps to SRAM word 0
//   write_data        store data
//   read_data         assembled load data, valid in DONE, held until next load
//   ready             pipeline freeze control (see handshake note below)
//   sram_addr         SRAM halfword address
//   sram_dq_out/oe    write data and its drive enable
//   sram_dq_in        data returned by SRAM
//   sram_we_n         active-low write strobe
//   state_o           debug view of the FSM state
//
// Handshake: a request is held by the pipeline while ready is low. ready is
// high when no request is present, or in the single DONE cycle that finishes
// the current one. A request still high in DONE counts as consumed; a new
// access begins only when the request is seen again in IDLE.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output state_e             state_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  // Offset relative to ADDR_BASE; addresses below the base wrap modulo 2^32.
  logic [31:0] rel_addr;
  logic [16:0] word_off;
  assign rel_addr = addr_q - ADDR_BASE;
  assign word_off = rel_addr[18:2];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state_q)
      IDLE: begin
        if (rd_en || wr_en) begin
          state_d = LOW;
          wait_d  = WAIT_LOAD;
          addr_d  = address;
          data_d  = write_data;
          wr_d    = wr_en;
        end
      end
      LOW: begin
        sram_addr = {word_off, 1'b0};
        if (wr_q) begin
          sram_dq_out = data_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (wait_q == 4'd0) begin
          state_d = HIGH;
          wait_d  = WAIT_LOAD;
          // Sample on the last cycle the address has been stable.
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HIGH: begin
        sram_addr = {word_off, 1'b1};
        if (wr_q) begin
          sram_dq_out = data_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (wait_q == 4'd0) begin
          state_d = DONE;
          wait_d  = 4'd0;
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready     = !(rd_en || wr_en) || (state_q == DONE);
  assign read_data = rdata_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: a default-parameter instance backed by a
// behavioural SRAM array, plus an SRAM_WAIT=1 instance backed by an
// address-derived data pattern for back-to-back timing.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int EXP_LOW_CYCLES = 2 * 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT (SRAM_WAIT = 2) ----------------
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
  state_e      state;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .state_o(state)
  );

  // ---------------- second DUT (SRAM_WAIT = 1) ----------------
  logic        w1_wr_en, w1_rd_en;
  logic [31:0] w1_address, w1_write_data, w1_read_data;
  logic        w1_ready;
  logic [17:0] w1_sram_addr;
  logic [15:0] w1_sram_dq_out, w1_sram_dq_in;
  logic        w1_sram_dq_oe, w1_sram_we_n;
  state_e      w1_state;

  sram_controller #(.ADDR_BASE(1024), .SRAM_WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst), .wr_en(w1_wr_en), .rd_en(w1_rd_en),
    .address(w1_address), .write_data(w1_write_data), .read_data(w1_read_data),
    .ready(w1_ready), .sram_addr(w1_sram_addr), .sram_dq_out(w1_sram_dq_out),
    .sram_dq_oe(w1_sram_dq_oe), .sram_dq_in(w1_sram_dq_in),
    .sram_we_n(w1_sram_we_n), .state_o(w1_state)
  );

  // ---------------- SRAM models ----------------
  bit [15:0] sram_mem [0:262143];
  bit [15:0] shadow   [0:262143];
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) sram_mem[pre_addr] <= pre_data;
    else if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[sram_addr];

  function automatic logic [15:0] pat(input logic [17:0] a);
    return a[15:0] ^ {14'h0, a[17:16]} ^ 16'hA5A5;
  endfunction
  assign w1_sram_dq_in = pat(w1_sram_addr);

  // Halfword address of the low half, derived from the modulo rule.
  function automatic logic [17:0] exp_hw(input logic [31:0] a);
    logic [31:0] r;
    r = a - 32'd1024;
    return {r[18:2], 1'b0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [17:0] hw, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = hw; pre_data = d;
    shadow[hw] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input string name);
    logic [17:0] hw;
    logic [17:0] seq[$];
    logic [31:0] exp_rd;
    int          low_cnt;
    bit          is_wr;
    hw      = exp_hw(addr);
    is_wr   = wr;
    low_cnt = 0;
    if (!is_wr) exp_q.push_back({shadow[hw | 18'd1], shadow[hw]});
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    #1;
    while (!ready && low_cnt < 40) begin
      if (state == LOW || state == HIGH) begin
        seq.push_back(sram_addr);
        n_checks++;
        if (sram_we_n !== !is_wr || sram_dq_oe !== is_wr)
          $display("FAIL %s_strobe: we_n=%b oe=%b required we_n=%b oe=%b",
                   name, sram_we_n, sram_dq_oe, !is_wr, is_wr);
        else n_pass++;
        if (is_wr) begin
          n_checks++;
          if (sram_dq_out !== ((state == LOW) ? data[15:0] : data[31:16]))
            $display("FAIL %s_dq_out: got %h required %h", name, sram_dq_out,
                     (state == LOW) ? data[15:0] : data[31:16]);
          else n_pass++;
        end
      end
      low_cnt++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (low_cnt !== EXP_LOW_CYCLES)
      $display("FAIL %s_latency: ready low %0d cycles required %0d", name, low_cnt, EXP_LOW_CYCLES);
    else n_pass++;
    n_checks++;
    if (seq.size() !== 4)
      $display("FAIL %s_addr_count: got %0d sram cycles required 4", name, seq.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seq[i] !== ((i < 2) ? hw : (hw | 18'd1)))
          $display("FAIL %s_addr[%0d]: got %h required %h", name, i, seq[i],
                   (i < 2) ? hw : (hw | 18'd1));
        else n_pass++;
      end
    end
    n_checks++;
    if (state !== DONE) $display("FAIL %s_done: state %0d required %0d", name, state, DONE);
    else n_pass++;
    if (!is_wr) begin
      if (exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        n_checks++;
        if (read_data !== exp_rd)
          $display("FAIL %s_read_data: got %h required %h", name, read_data, exp_rd);
        else n_pass++;
        last_rd = exp_rd;
      end
    end else begin
      n_checks++;
      if (read_data !== last_rd)
        $display("FAIL %s_read_hold: got %h required %h", name, read_data, last_rd);
      else n_pass++;
      shadow[hw]          = data[15:0];
      shadow[hw | 18'd1]  = data[31:16];
      n_checks++;
      if (sram_mem[hw] !== shadow[hw] || sram_mem[hw | 18'd1] !== shadow[hw | 18'd1])
        $display("FAIL %s_sram_contents: got %h_%h required %h_%h", name,
                 sram_mem[hw | 18'd1], sram_mem[hw], shadow[hw | 18'd1], shadow[hw]);
      else n_pass++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (state !== IDLE || ready !== 1'b1)
      $display("FAIL %s_return_idle: state=%0d ready=%b required state=%0d ready=1", name, state, ready, IDLE);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    wr_en = 0; rd_en = 0; address = '0; write_data = '0;
    w1_wr_en = 0; w1_rd_en = 0; w1_address = '0; w1_write_data = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (state !== IDLE || w1_state !== IDLE)
      $display("FAIL reset_state: got %0d/%0d required %0d", state, w1_state, IDLE);
    else n_pass++;
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0)
      $display("FAIL reset_pins: we_n=%b oe=%b addr=%h required 1,0,0", sram_we_n, sram_dq_oe, sram_addr);
    else n_pass++;
    n_checks++;
    if (read_data !== 32'h0 || ready !== 1'b1)
      $display("FAIL reset_outputs: read_data=%h ready=%b required 0,1", read_data, ready);
    else n_pass++;
    last_rd = 32'h0;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr1024");
    access(1'b0, 1'b1, 32'd1024, 32'h0, "rd1024");
  endtask

  task automatic test_read_seq;
    preload(18'd4, 16'h1234);
    preload(18'd5, 16'h5678);
    access(1'b0, 1'b1, 32'd1032, 32'h0, "rd1032");
  endtask

  task automatic test_both_requests;
    access(1'b1, 1'b1, 32'd1028, 32'h00000001, "both");
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h12345678;
    n = 0;
    #1;
    while (state !== HIGH && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (state !== HIGH) $display("FAIL rstmid_reach_high: state %0d required %0d", state, HIGH);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (state !== IDLE || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
      $display("FAIL rstmid_abandon: state=%0d we_n=%b oe=%b required %0d,1,0", state, sram_we_n, sram_dq_oe, IDLE);
    else n_pass++;
    n_checks++;
    if (read_data !== 32'h0) $display("FAIL rstmid_read_data: got %h required 0", read_data);
    else n_pass++;
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b required 1", ready);
    else n_pass++;
    rst = 1'b0;
    last_rd = 32'h0;
    n_checks++;
    if (sram_mem[2] !== 16'h5678) $display("FAIL rstmid_low_half: got %h required 5678", sram_mem[2]);
    else n_pass++;
    shadow[2] = 16'h5678;
    preload(18'd3, 16'hC0DE);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sram_mem[3] !== 16'hC0DE) $display("FAIL rstmid_no_more_writes: got %h required c0de", sram_mem[3]);
    else n_pass++;
  endtask

  task automatic test_wrap;
    access(1'b1, 1'b0, 32'd0, 32'hA1B2C3D4, "wrap_wr");
    access(1'b0, 1'b1, 32'd0, 32'h0, "wrap_rd");
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = 32'd1024 + 32'd4 * (32'd100 + 32'($urandom_range(0, 200))) + 32'($urandom_range(0, 3));
      d = $urandom;
      access(1'b1, 1'b0, a, d, "rand_wr");
      access(1'b0, 1'b1, a, 32'h0, "rand_rd");
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, exp_rd;
    logic [17:0] hw;
    int done_cyc[$];
    int cyc;
    @(negedge clk);
    a  = 32'd1024 + 32'd40;
    hw = exp_hw(a);
    exp_q.push_back({pat(hw | 18'd1), pat(hw)});
    w1_address = a; w1_rd_en = 1'b1;
    cyc = 0;
    #1;
    while (done_cyc.size() < 3 && cyc < 40) begin
      if (w1_ready) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          n_checks++;
          if (w1_read_data !== exp_rd)
            $display("FAIL b2b_read_data: got %h required %h", w1_read_data, exp_rd);
          else n_pass++;
        end
        if (done_cyc.size() < 3) begin
          a  = a + 32'd4 * 32'($urandom_range(1, 50));
          hw = exp_hw(a);
          exp_q.push_back({pat(hw | 18'd1), pat(hw)});
          w1_address = a;
        end
      end
      @(negedge clk); #1;
      cyc++;
    end
    w1_rd_en = 1'b0;
    n_checks++;
    if (done_cyc.size() !== 3)
      $display("FAIL b2b_count: got %0d completions required 3", done_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (done_cyc[0] !== 3) $display("FAIL b2b_first_latency: done at cycle %0d required 3", done_cyc[0]);
      else n_pass++;
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (done_cyc[i] - done_cyc[i-1] !== 4)
          $display("FAIL b2b_period[%0d]: got %0d cycles required 4", i, done_cyc[i] - done_cyc[i-1]);
        else n_pass++;
      end
    end
    #1;
    n_checks++;
    if (w1_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b required 1", w1_ready);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_read_seq();
    test_both_requests();
    test_reset_mid();
    test_wrap();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
